dct_transpose: RTL and testbench
================================

DCT_TRANSPOSE -- requirements
Module: dct_transpose

Block position: sits between the row-pass and column-pass 1-D 8-point DCT stages. It accepts 8-sample rows and emits 8-sample columns of each 8x8 block, using a ping-pong buffer.

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 8, giving the sample width in bits (equal to the 1-D DCT stage width).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: row_in holds a valid row.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a row this cycle.
REQ-006 SHALL have port row_in, input, PIX_WIDTH x [7:0]: row samples, where index i is column i.
REQ-007 SHALL have port out_valid, output, 1 bit: col_out holds a valid column.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream stage takes the column.
REQ-009 SHALL have port col_out, output, PIX_WIDTH x [7:0]: column samples, where index i is row i.

Function
REQ-010 SHALL hold two banks (0, 1), each of 8x8 PIX_WIDTH words, plus per-bank full flags.
REQ-011 SHALL treat a row as accepted when in_valid && in_ready at a rising edge, and a column as delivered when out_valid && out_ready.
REQ-012 SHALL write an accepted row into bank wr_bank at row index wr_row (0..7), then increment wr_row.
REQ-013 SHALL, on acceptance with wr_row==7, set full[wr_bank], wrap wr_row to 0 and toggle wr_bank.
REQ-014 SHALL drive in_ready = !full[wr_bank], which is a registered-state function with no combinational path from out_ready.
REQ-015 SHALL drive out_valid = full[rd_bank], and col_out[i] = bank[rd_bank][row i][column rd_col].
REQ-016 SHALL, on delivery, increment rd_col; with rd_col==7 it SHALL clear full[rd_bank], wrap rd_col to 0 and toggle rd_bank.
REQ-017 SHALL hold col_out and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL allow a write to one bank and a read of the other in the same cycle.
REQ-019 SHALL apply both flag updates when a bank completes fill and the other completes drain in the same cycle.
REQ-020 SHALL deliver the first column of a block at the edge after its 8th row is accepted (out_valid high 1 cycle later); latency is 1 cycle from last row to first column.
REQ-021 SHALL sustain 1 row in and 1 column out per cycle with in_valid and out_ready held high; no bubbles after the first block.
REQ-022 SHALL NOT alter samples: it performs no arithmetic, widening or truncation; a bit-exact transpose only.
REQ-023 SHALL ignore row_in when in_ready is low, and SHALL NOT overwrite a full bank.
REQ-024 SHALL drop a partially written block silently if rst is asserted mid-block; no partial output.

Reset
REQ-025 SHALL, while rst is high at an edge, clear wr_row, rd_col, wr_bank, rd_bank, both full flags and all storage to 0.
REQ-026 SHALL present in_ready=1, out_valid=0 and col_out all 0 after a reset edge.
REQ-027 SHALL give rst priority over any simultaneous transfer.

Verification
REQ-028 Single block: rows r=0..7 with row_in[c]=8r+c, out_ready=1 -> 1 cycle after the last row, 8 consecutive columns with col_out[i]=8i+c for c=0..7; then out_valid=0.
REQ-029 Back-pressure: two blocks back to back with out_ready=0 -> in_ready drops after 16 rows accepted; 17th row is not written; release -> block A columns, then block B columns intact.
REQ-030 Streaming: in_valid=out_ready=1 for 64 cycles of 8 blocks -> no in_ready low after reset; every block transposes correctly; output is contiguous from the 9th cycle.
REQ-031 Stall mid-drain: out_ready toggled 1,0,0,1 during column 3 -> col_out held constant with out_valid=1; no column is skipped or repeated.
REQ-032 Reset mid-operation: rst after 5 rows of block A and during drain of a prior block -> next cycle out_valid=0, in_ready=1, col_out=0; a subsequent fresh block transposes correctly from bank 0.
REQ-033 Width: PIX_WIDTH=12, samples 12'hFFF and 12'h800 in the single-block pattern -> output bit-exact.

Source files
------------

// File: rtl/dct_transpose_if.sv
// Row-in / column-out handshake bundle for the 8x8 DCT transpose stage.
// The master side drives rows and column-ready; the slave side is the transpose block.
interface dct_transpose_if #(
  parameter int unsigned PIX_WIDTH = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [7:0][PIX_WIDTH-1:0]     row_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [7:0][PIX_WIDTH-1:0]     col_out;

  modport master (
    output in_valid, row_in, out_ready,
    input  in_ready, out_valid, col_out
  );

  modport slave (
    input  in_valid, row_in, out_ready,
    output in_ready, out_valid, col_out
  );
endinterface

// File: rtl/dct_transpose.sv
// Ping-pong 8x8 transpose between the row and column 1-D DCT passes:
// rows are written into one bank while columns of the other bank are read out.
module dct_transpose #(
  parameter int unsigned PIX_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  dct_transpose_if.slave bus
);
  typedef logic [PIX_WIDTH-1:0] word_t;

  word_t      mem_q [2][8][8];
  word_t      mem_d [2][8][8];
  logic [2:0] wr_row_q, wr_row_d;
  logic [2:0] rd_col_q, rd_col_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic deliver;

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = !full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    accept    = bus.in_valid && in_ready;
    deliver   = out_valid && bus.out_ready;
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    for (int unsigned i = 0; i < 8; i++) begin
      bus.col_out[i] = mem_q[rd_bank_q][3'(i)][rd_col_q];
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    rd_col_d  = rd_col_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (accept) begin
      for (int unsigned c = 0; c < 8; c++) begin
        mem_d[wr_bank_q][wr_row_q][3'(c)] = bus.row_in[c];
      end
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    // Fill and drain always target different banks, so both flag updates can land together.
    if (deliver) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned r = 0; r < 8; r++) begin
          for (int unsigned c = 0; c < 8; c++) begin
            mem_q[b][r][c] <= '0;
          end
        end
      end
      wr_row_q  <= '0;
      rd_col_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end
endmodule

// File: tb/tb_dct_transpose.sv
// Bench for dct_transpose: a queue-based transpose model predicts in_ready,
// out_valid and col_out every cycle; a few literal columns pin the model.
module tb_dct_transpose;
  localparam int unsigned W = 12;
  typedef logic [7:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_transpose_if #(.PIX_WIDTH(W)) bus ();
  dct_transpose #(.PIX_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  vec_t colq[$];
  vec_t part[8];
  int   part_n = 0;
  bit   post_reset = 1'b1;
  bit   lit_col_en = 1'b0;
  vec_t lit_col;
  bit   lit_ir_en = 1'b0;
  logic lit_ir;

  task automatic chk(string name, logic [8*W-1:0] act, logic [8*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t pat_row(int r);
    vec_t v;
    for (int c = 0; c < 8; c++) v[c] = W'(8 * r + c);
    return v;
  endfunction

  function automatic vec_t pat_col(int c);
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = W'(8 * i + c);
    return v;
  endfunction

  function automatic vec_t rnd_row();
    vec_t v;
    for (int c = 0; c < 8; c++) v[c] = W'($urandom);
    return v;
  endfunction

  // One cycle: drive after the edge, compare at negedge, advance the model at the next edge.
  task automatic tick(bit r, bit iv, vec_t row, bit ordy);
    bit   acc;
    bit   dlv;
    vec_t col;
    #1;
    rst = r; bus.in_valid = iv; bus.row_in = row; bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", bus.in_ready, colq.size() <= 8);
    chk("out_valid", bus.out_valid, colq.size() > 0);
    if (colq.size() > 0) chk("col_out", bus.col_out, colq[0]);
    if (post_reset) chk("col_out_after_reset", bus.col_out, '0);
    if (lit_col_en) begin
      chk("literal_col", bus.col_out, lit_col);
      chk("literal_valid", bus.out_valid, 1'b1);
      lit_col_en = 1'b0;
    end
    if (lit_ir_en) begin
      chk("literal_in_ready", bus.in_ready, lit_ir);
      lit_ir_en = 1'b0;
    end
    @(posedge clk);
    if (r) begin
      colq.delete();
      part_n     = 0;
      post_reset = 1'b1;
    end else begin
      acc = iv && (colq.size() <= 8);
      dlv = ordy && (colq.size() > 0);
      post_reset = 1'b0;
      if (dlv) void'(colq.pop_front());
      if (acc) begin
        part[part_n] = row;
        part_n++;
        if (part_n == 8) begin
          for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++) col[i] = part[i][c];
            colq.push_back(col);
          end
          part_n = 0;
        end
      end
    end
  endtask

  task automatic idle(int n, bit ordy);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0, ordy);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; bus.in_valid = 1'b0; bus.row_in = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);

    // Single block, column 0 expected one cycle after the last row.
    for (int r = 0; r < 8; r++) tick(1'b0, 1'b1, pat_row(r), 1'b1);
    lit_col_en = 1'b1; lit_col = pat_col(0);
    tick(1'b0, 1'b0, '0, 1'b1);
    idle(10, 1'b1);

    // Full-scale sample values pass through untouched.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) v[c] = ((r + c) % 2 != 0) ? 12'h800 : 12'hFFF;
      tick(1'b0, 1'b1, v, 1'b1);
    end
    for (int i = 0; i < 8; i++) lit_col[i] = (i % 2 != 0) ? 12'h800 : 12'hFFF;
    lit_col_en = 1'b1;
    tick(1'b0, 1'b0, '0, 1'b1);
    idle(10, 1'b1);

    // Back-pressure: two blocks fill both banks, the 17th row is refused.
    for (int k = 0; k < 19; k++) begin
      if (k == 16) begin lit_ir_en = 1'b1; lit_ir = 1'b0; end
      tick(1'b0, 1'b1, rnd_row(), 1'b0);
    end
    idle(20, 1'b1);

    // Streaming with both sides always ready.
    for (int k = 0; k < 72; k++) tick(1'b0, 1'b1, rnd_row(), 1'b1);
    idle(10, 1'b1);

    // Stall while column 3 is presented.
    for (int r = 0; r < 8; r++) tick(1'b0, 1'b1, pat_row(r), 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k >= 3 && k <= 5) begin lit_col_en = 1'b1; lit_col = pat_col(3); end
      tick(1'b0, 1'b0, '0, (k == 3 || k == 4) ? 1'b0 : 1'b1);
    end
    idle(4, 1'b1);

    // Reset mid-fill and mid-drain, then a fresh block.
    for (int r = 0; r < 8; r++) tick(1'b0, 1'b1, rnd_row(), 1'b0);
    for (int r = 0; r < 5; r++) tick(1'b0, 1'b1, rnd_row(), 1'b1);
    tick(1'b1, 1'b1, rnd_row(), 1'b1);
    for (int r = 0; r < 8; r++) tick(1'b0, 1'b1, pat_row(r), 1'b1);
    lit_col_en = 1'b1; lit_col = pat_col(0);
    tick(1'b0, 1'b0, '0, 1'b1);
    idle(10, 1'b1);

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           rnd_row(), ($urandom_range(0, 2) != 0));
    end
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
